// File: rtl/pc_sequencer.sv
// Program-counter stage: registers the next fetch address from hold/inc/jump/branch/call/ret
// and keeps return addresses in a small LIFO with full/empty and sticky error flags.

module pc_incrementer (
    input  logic [15:0] a,
    output logic [15:0] y
);
    assign y = a + 16'd1;
endmodule

module pc_sequencer #(
    parameter int          STACK_DEPTH  = 4,
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [2:0]                           op,
    input  logic                                 cond,
    input  logic [15:0]                          target,
    input  logic                                 err_clr,
    output logic [15:0]                          pc,
    output logic [15:0]                          pc_inc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
    output logic                                 stack_full,
    output logic                                 stack_empty,
    output logic                                 ovf_err,
    output logic                                 unf_err
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;

    logic [15:0]   stack [STACK_DEPTH];
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;
    logic [15:0]   pc_nxt;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          unf_set;

    pc_incrementer u_inc (
        .a (pc),
        .y (pc_inc)
    );

    assign stack_full  = (depth == FULL_DEPTH);
    assign stack_empty = (depth == '0);
    assign push_idx    = depth[AW-1:0];
    assign pop_idx     = push_idx - AW'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        pc_nxt  = pc;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            case (op)
                OP_HOLD:   pc_nxt = pc;
                OP_INC:    pc_nxt = pc_inc;
                OP_JUMP:   pc_nxt = target;
                OP_BRANCH: pc_nxt = cond ? target : pc_inc;
                OP_CALL: begin
                    pc_nxt  = target;
                    push    = !stack_full;
                    ovf_set = stack_full;
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_nxt  = pc_inc;
                        unf_set = 1'b1;
                    end else begin
                        pc_nxt = stack[pop_idx];
                        pop    = 1'b1;
                    end
                end
                default: pc_nxt = pc;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            depth   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (en) begin
                pc <= pc_nxt;
                if (push)
                    depth <= depth + DW'(1);
                else if (pop)
                    depth <= depth - DW'(1);
            end
            // A new error on the same edge as err_clr keeps the flag set.
            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            unf_err <= unf_set | (unf_err & ~err_clr);
        end
    end

    // NOTE: the stack array has no reset; depth alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            stack[push_idx] <= pc_inc;
    end

endmodule
